// File: rtl/reset_sequencer.sv
// Power-up / soft-reset sequencer: filters PLL lock, then releases
// per-channel enables one at a time; drops them on lock loss or request.
module reset_sequencer #(
  parameter int N_CH      = 4,
  parameter int STAGE_DLY = 62,
  parameter int LOCK_FILT = 16,
  parameter int HOLD_CYC  = 8
) (
  input  logic            clk40,
  input  logic            rst,
  input  logic            lock,
  input  logic            req,
  output logic [N_CH-1:0] en,
  output logic            done,
  output logic [1:0]      state
);

  localparam int LW = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
  localparam int DW = (STAGE_DLY > 1) ? $clog2(STAGE_DLY) : 1;
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [LW-1:0] LC_END = LW'(LOCK_FILT - 1);
  localparam logic [DW-1:0] DC_END = DW'(STAGE_DLY - 1);
  localparam logic [IW-1:0] IX_END = IW'(N_CH - 1);
  localparam logic [HW-1:0] HC_END = HW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STAGE     = 2'd1,
    RUN       = 2'd2,
    HOLD      = 2'd3
  } st_t;

  // Declaration initialisers give power-up == reset with rst tied low.
  st_t            st_q   = WAIT_LOCK;
  logic [N_CH-1:0] en_q  = '0;
  logic           done_q = 1'b0;
  logic [LW-1:0]  lc_q   = '0;
  logic [DW-1:0]  dc_q   = '0;
  logic [IW-1:0]  ix_q   = '0;
  logic [HW-1:0]  hc_q   = '0;

  st_t             st_d;
  logic [N_CH-1:0] en_d;
  logic            done_d;
  logic [LW-1:0]   lc_d;
  logic [DW-1:0]   dc_d;
  logic [IW-1:0]   ix_d;
  logic [HW-1:0]   hc_d;

  always_ff @(posedge clk40) begin
    if (rst) begin
      st_q   <= WAIT_LOCK;
      en_q   <= '0;
      done_q <= 1'b0;
      lc_q   <= '0;
      dc_q   <= '0;
      ix_q   <= '0;
      hc_q   <= '0;
    end else begin
      st_q   <= st_d;
      en_q   <= en_d;
      done_q <= done_d;
      lc_q   <= lc_d;
      dc_q   <= dc_d;
      ix_q   <= ix_d;
      hc_q   <= hc_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    en_d   = en_q;
    done_d = done_q;
    lc_d   = lc_q;
    dc_d   = dc_q;
    ix_d   = ix_q;
    hc_d   = hc_q;
    if (st_q != WAIT_LOCK && !lock) begin
      st_d   = WAIT_LOCK;
      en_d   = '0;
      done_d = 1'b0;
      lc_d   = '0;
      dc_d   = '0;
      ix_d   = '0;
      hc_d   = '0;
    end else if ((st_q == STAGE || st_q == RUN) && req) begin
      st_d   = HOLD;
      en_d   = '0;
      done_d = 1'b0;
      dc_d   = '0;
      ix_d   = '0;
      hc_d   = '0;
    end else begin
      unique case (st_q)
        WAIT_LOCK: begin
          en_d   = '0;
          done_d = 1'b0;
          if (!lock) begin
            lc_d = '0;
          end else if (lc_q == LC_END) begin
            lc_d = '0;
            st_d = STAGE;
            ix_d = '0;
            dc_d = '0;
          end else begin
            lc_d = lc_q + 1'b1;
          end
        end
        STAGE: begin
          if (dc_q == DC_END) begin
            dc_d = '0;
            en_d = en_q | (N_CH'(1) << ix_q);
            if (ix_q == IX_END) begin
              st_d   = RUN;
              done_d = 1'b1;
            end else begin
              ix_d = ix_q + 1'b1;
            end
          end else begin
            dc_d = dc_q + 1'b1;
          end
        end
        RUN: begin
          done_d = 1'b1;
        end
        HOLD: begin
          // A still-high request at the end restarts the hold window.
          if (hc_q == HC_END) begin
            hc_d = '0;
            if (!req) begin
              st_d = STAGE;
              ix_d = '0;
              dc_d = '0;
            end
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
        default: st_d = WAIT_LOCK;
      endcase
    end
  end

  assign en    = en_q;
  assign done  = done_q;
  assign state = st_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: per-cycle vector table built from the
// expected release timeline, checked through a scoreboard queue.
module tb_reset_sequencer;

  localparam int NV = 123;

  typedef struct {
    int         idx;
    logic       rst;
    logic       lock;
    logic       req;
    logic [2:0] en;
    logic       done;
    logic [1:0] st;
  } vec_t;

  logic       clk40 = 1'b1;
  logic       rst   = 1'b0;
  logic       lock  = 1'b0;
  logic       req   = 1'b0;
  logic [2:0] en;
  logic       done;
  logic [1:0] state;

  vec_t v[NV];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  reset_sequencer #(
    .N_CH(3),
    .STAGE_DLY(4),
    .LOCK_FILT(3),
    .HOLD_CYC(2)
  ) dut (
    .clk40(clk40),
    .rst(rst),
    .lock(lock),
    .req(req),
    .en(en),
    .done(done),
    .state(state)
  );

  always #5 clk40 = ~clk40;

  // Rows before fs show state pre; from fs one enable every 4 clocks.
  task automatic fill(input int from, input int to, input int fs,
                      input logic [1:0] pre);
    int r;
    for (int k = from; k <= to; k++) begin
      if (k < fs) begin
        v[k].en   = 3'b000;
        v[k].done = 1'b0;
        v[k].st   = pre;
      end else begin
        r = (k - fs) / 4;
        if (r > 3) r = 3;
        v[k].en   = 3'((1 << r) - 1);
        v[k].done = (r == 3);
        v[k].st   = (r == 3) ? 2'd2 : 2'd1;
      end
    end
  endtask

  task automatic set_run(input int k);
    v[k].en   = 3'b111;
    v[k].done = 1'b1;
    v[k].st   = 2'd2;
  endtask

  always @(negedge clk40) begin
    vec_t e;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if ($isunknown({en, done, state})) begin
        bad++;
        $display("FAIL xcheck row %0d: got en=%b done=%b state=%b, need no X",
                 e.idx, en, done, state);
      end
      total++;
      if (en !== e.en || done !== e.done || state !== e.st) begin
        bad++;
        $display("FAIL row %0d: got en=%b done=%b state=%0d, need en=%b done=%b state=%0d",
                 e.idx, en, done, state, e.en, e.done, e.st);
      end
    end
  end

  initial begin
    for (int k = 0; k < NV; k++) begin
      v[k].idx  = k;
      v[k].rst  = 1'b0;
      v[k].lock = 1'b1;
      v[k].req  = 1'b0;
    end
    // Power-up without rst, lock high from the first clock.
    fill(0, 19, 3, 2'd0);
    // One-cycle req pulse in RUN.
    v[20].req = 1'b1;
    fill(20, 37, 23, 2'd3);
    set_run(20);
    // One-cycle lock drop in RUN, lock back from row 39.
    v[38].lock = 1'b0;
    set_run(38);
    fill(39, 55, 42, 2'd0);
    // rst in RUN, then lock glitch at c+2.
    v[56].rst = 1'b1;
    set_run(56);
    v[59].lock = 1'b0;
    fill(57, 76, 63, 2'd0);
    // rst again, then rst+req while en=001 in STAGE.
    v[77].rst = 1'b1;
    set_run(77);
    fill(78, 86, 81, 2'd0);
    v[86].rst = 1'b1;
    v[86].req = 1'b1;
    // req in WAIT_LOCK is ignored.
    v[88].req = 1'b1;
    fill(87, 103, 90, 2'd0);
    // Held req keeps the block in HOLD.
    for (int k = 103; k <= 108; k++) v[k].req = 1'b1;
    fill(104, 122, 110, 2'd3);

    for (int k = 0; k < NV; k++) begin
      @(negedge clk40);
      rst  = v[k].rst;
      lock = v[k].lock;
      req  = v[k].req;
      sb.push_back(v[k]);
    end
    @(negedge clk40);
    #4;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, need 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
